// File: rtl/decode_pkg.sv
// Shared decode-stage definitions: hazard-controller FSM encoding and the
// ID-stage opcode of the cache-switch instruction.
package decode_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN      = 2'd0,
        ST_STALL    = 2'd1,
        ST_CSW_WAIT = 2'd2,
        ST_FLUSH    = 2'd3
    } state_e;

    // custom-0 major opcode, used by the decoder to flag id_switch_cache
    localparam logic [6:0] OPC_SWITCH_CACHE = 7'b0001011;

endpackage

// File: rtl/load_scoreboard.sv
// Load-use scoreboard: tracks in-flight loads that have left EX but cannot
// yet forward, and flags when an ID source register depends on one of them
// or on a load currently in EX.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   ex_mem_read/ex_rd_addr load currently in EX and its destination
//   ex_is_bubble           the instruction now in EX was inserted as a bubble
//   rs1_addr/rs2_addr      ID source registers, qualified by use_rs1/use_rs2
//   match                  a used source depends on an unfinished load
module load_scoreboard
    import decode_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned LOAD_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_is_bubble,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic                  use_rs1,
    input  logic                  use_rs2,
    output logic                  match
);

    localparam int unsigned DEPTH = LOAD_LAT - 1;

    logic ex_hit;
    logic sb_hit;

    // x0 is never a real destination, so it can never create a dependency
    always_comb begin
        ex_hit = 1'b0;
        if (ex_mem_read && (ex_rd_addr != '0)) begin
            ex_hit = (use_rs1 && (rs1_addr == ex_rd_addr)) ||
                     (use_rs2 && (rs2_addr == ex_rd_addr));
        end
    end

    generate
        if (DEPTH == 0) begin : g_empty
            logic unused_sb;
            assign unused_sb = ^{clk, reset, ex_is_bubble};
            assign sb_hit    = 1'b0;
        end else begin : g_regs
            logic [DEPTH-1:0]                 vld_q;
            logic [DEPTH-1:0][REG_ADDR_W-1:0] rd_q;
            logic                             capture;

            // A NOP we injected must not be mistaken for the load it displaced
            assign capture = ex_mem_read && (ex_rd_addr != '0) && !ex_is_bubble;

            // Shift register of loads, one entry per cycle since leaving EX
            always_ff @(posedge clk) begin
                if (reset) begin
                    vld_q <= '0;
                    rd_q  <= '0;
                end else begin
                    vld_q[0] <= capture;
                    rd_q[0]  <= ex_rd_addr;
                    for (int k = 1; k < DEPTH; k++) begin
                        vld_q[k] <= vld_q[k-1];
                        rd_q[k]  <= rd_q[k-1];
                    end
                end
            end

            always_comb begin
                sb_hit = 1'b0;
                for (int k = 0; k < DEPTH; k++) begin
                    if (vld_q[k] && ((use_rs1 && (rs1_addr == rd_q[k])) ||
                                     (use_rs2 && (rs2_addr == rd_q[k])))) begin
                        sb_hit = 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign match = ex_hit || sb_hit;

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage hazard controller: load-use stalls, branch/jump flushes and
// the cache-switch handshake, plus a saturating stall statistic.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   id_*                             instruction in ID (sources, switch flag)
//   ex_mem_read, ex_rd_addr          load in EX
//   branch_jump_taken                EX resolved a taken control transfer
//   csw_ack                          cache controller finished the switch
//   stat_clr                         clears stall_count
//   hold_if/hold_id/bubble_ex        combinational stall controls
//   flush_if/flush_id                combinational flush controls
//   csw_req, csw_timeout_err         registered handshake and sticky error
//   stall_count, state               statistics and FSM state
module decode_hazard_ctrl
    import decode_pkg::*;
#(
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned LOAD_LAT     = 1,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CSW_TIMEOUT  = 255,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  id_switch_cache,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  branch_jump_taken,
    input  logic                  csw_ack,
    input  logic                  stat_clr,
    output logic                  hold_if,
    output logic                  hold_id,
    output logic                  bubble_ex,
    output logic                  flush_if,
    output logic                  flush_id,
    output logic                  csw_req,
    output logic                  csw_timeout_err,
    output logic [CNT_W-1:0]      stall_count,
    output logic [STATE_W-1:0]    state
);

    localparam int unsigned WAIT_W = $clog2(CSW_TIMEOUT + 1);
    localparam int unsigned FL_W   = 3;

    state_e            state_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [FL_W-1:0]   flush_rem_q;
    logic              ex_bubble_q;
    logic              ld_hit;
    logic              hazard;
    logic              hold;
    logic              flush;

    load_scoreboard #(
        .REG_ADDR_W (REG_ADDR_W),
        .LOAD_LAT   (LOAD_LAT)
    ) u_load_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .ex_mem_read  (ex_mem_read),
        .ex_rd_addr   (ex_rd_addr),
        .ex_is_bubble (ex_bubble_q),
        .rs1_addr     (id_rs1_addr),
        .rs2_addr     (id_rs2_addr),
        .use_rs1      (id_uses_rs1),
        .use_rs2      (id_uses_rs2),
        .match        (ld_hit)
    );

    assign hazard = id_valid && ld_hit;

    // Same-cycle stall/flush decisions; branch wins over hazard over switch
    always_comb begin
        hold  = 1'b0;
        flush = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_RUN, ST_STALL: begin
                    if (branch_jump_taken) begin
                        flush = 1'b1;
                    end else if (hazard || (id_valid && id_switch_cache)) begin
                        hold = 1'b1;
                    end
                end
                ST_CSW_WAIT: hold  = 1'b1;
                ST_FLUSH:    flush = 1'b1;
                default:     ;
            endcase
        end
    end

    assign hold_if   = hold;
    assign hold_id   = hold;
    assign bubble_ex = hold;
    assign flush_if  = flush;
    assign flush_id  = flush;
    assign state     = state_q;

    // FSM, handshake, counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_RUN;
            wait_cnt_q      <= '0;
            flush_rem_q     <= '0;
            ex_bubble_q     <= 1'b0;
            csw_req         <= 1'b0;
            csw_timeout_err <= 1'b0;
            stall_count     <= '0;
        end else begin
            ex_bubble_q <= bubble_ex;

            if (stat_clr) begin
                stall_count <= '0;
            end else if (hold_id && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end

            case (state_q)
                ST_RUN, ST_STALL: begin
                    if (branch_jump_taken) begin
                        // The branch cycle itself is the first flush cycle
                        if (FLUSH_CYCLES > 1) begin
                            state_q     <= ST_FLUSH;
                            flush_rem_q <= FL_W'(FLUSH_CYCLES - 1);
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end else if (hazard) begin
                        state_q <= ST_STALL;
                    end else if (id_valid && id_switch_cache) begin
                        state_q    <= ST_CSW_WAIT;
                        csw_req    <= 1'b1;
                        wait_cnt_q <= '0;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_CSW_WAIT: begin
                    // EX holds only bubbles here, so branches cannot occur
                    if (csw_ack) begin
                        state_q <= ST_RUN;
                        csw_req <= 1'b0;
                    end else if (wait_cnt_q == WAIT_W'(CSW_TIMEOUT - 1)) begin
                        state_q         <= ST_RUN;
                        csw_req         <= 1'b0;
                        csw_timeout_err <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
                end
                ST_FLUSH: begin
                    if (branch_jump_taken) begin
                        flush_rem_q <= FL_W'(FLUSH_CYCLES - 1);
                    end else if (flush_rem_q == FL_W'(1)) begin
                        state_q <= ST_RUN;
                    end else begin
                        flush_rem_q <= flush_rem_q - FL_W'(1);
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

endmodule
